ahb_slave_port_mux: RTL and testbench

Slave-side port multiplexer placed directly downstream of the per-slave AHB arbiter. It uses the arbiter's one-hot `hgrant` to route the granted master's address/control phase to the slave, and tracks the data-phase owner to route `hwdata`. It returns `hrdata`/`hready`/`hresp` to the masters and drives `hwait`/`hburst` back to the arbiter. An optional watchdog turns a hung slave into a two-cycle ERROR response.

---
 rtl/ahb_slave_port_mux_pkg.sv | 15 +
 rtl/ahb_onehot_mux.sv | 14 +
 rtl/ahb_slave_port_mux.sv | 120 ++++++++++++
 tb/tb_ahb_slave_port_mux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_port_mux_pkg.sv
// ahb_slave_port_mux_pkg: AHB transfer/response/burst types and watchdog state encodings.
package ahb_slave_port_mux_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_type;
  typedef enum logic [1:0] {OKAY, ERROR, RETRY, SPLIT} hresp_type;
  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_type;
  typedef logic [2:0] wd_state_t;
  localparam wd_state_t WD_IDLE  = 3'd0;
  localparam wd_state_t WD_WAIT  = 3'd1;
  localparam wd_state_t WD_ERR1  = 3'd2;
  localparam wd_state_t WD_ERR2  = 3'd3;
  localparam wd_state_t WD_DRAIN = 3'd4;
  function automatic logic is_active(input htrans_type t);
    return t == NONSEQ || t == SEQ;
  endfunction
endpackage

// File: rtl/ahb_onehot_mux.sv
// ahb_onehot_mux: N-way W-bit one-hot mux; lowest set select bit wins, zero when none set.
module ahb_onehot_mux #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] d,
  output logic [W-1:0]        q
);
  always_comb begin
    q = '0;
    for (int i = N - 1; i >= 0; i--) if (sel[i]) q = d[i];
  end
endmodule

// File: rtl/ahb_slave_port_mux.sv
// ahb_slave_port_mux: routes the granted master to one AHB slave and returns responses.
// Define SLAVE_TIMEOUT_EN to build the hung-slave watchdog (ERR1/ERR2/DRAIN sequence).
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int MASTER_NUM = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                                hclk,
  input  logic                                hreset_n,
  input  logic       [MASTER_NUM-1:0]         hgrant,
  input  logic       [MASTER_NUM-1:0][ADDR_W-1:0] m_haddr,
  input  htrans_type [MASTER_NUM-1:0]         m_htrans,
  input  logic       [MASTER_NUM-1:0]         m_hwrite,
  input  logic       [MASTER_NUM-1:0][2:0]    m_hsize,
  input  hburst_type [MASTER_NUM-1:0]         m_hburst,
  input  logic       [MASTER_NUM-1:0][DATA_W-1:0] m_hwdata,
  output logic       [DATA_W-1:0]             m_hrdata,
  output logic       [MASTER_NUM-1:0]         m_hready,
  output hresp_type  [MASTER_NUM-1:0]         m_hresp,
  output logic                                s_hsel,
  output logic       [ADDR_W-1:0]             s_haddr,
  output htrans_type                          s_htrans,
  output logic                                s_hwrite,
  output logic       [2:0]                    s_hsize,
  output hburst_type                          s_hburst,
  output logic       [DATA_W-1:0]             s_hwdata,
  output logic                                s_hready,
  input  logic                                s_hreadyout,
  input  logic       [DATA_W-1:0]             s_hrdata,
  input  hresp_type                           s_hresp,
  output logic                                hwait,
  output hburst_type                          hburst
);
  localparam int AC_W = ADDR_W + 9;
  logic [MASTER_NUM-1:0] gnt, dp_owner_q, dp_owner_d;
  logic dp_valid_q, dp_valid_d, hready_eff, blk, err, clr;
  logic [MASTER_NUM-1:0][AC_W-1:0] ac;
  logic [AC_W-1:0] ac_y;
  logic [DATA_W-1:0] wd_y;
  logic [1:0] htr;
  logic [2:0] hb;
  assign gnt = hgrant & (-hgrant);
  always_comb
    for (int i = 0; i < MASTER_NUM; i++)
      ac[i] = {m_haddr[i], m_htrans[i], m_hwrite[i], m_hsize[i], m_hburst[i]};
  ahb_onehot_mux #(.W(AC_W), .N(MASTER_NUM)) u_ac_mux (.sel(hgrant), .d(ac), .q(ac_y));
  ahb_onehot_mux #(.W(DATA_W), .N(MASTER_NUM)) u_wd_mux (.sel(dp_owner_q), .d(m_hwdata), .q(wd_y));
  assign {s_haddr, htr, s_hwrite, s_hsize, hb} = ac_y;
  assign s_hburst = hburst_type'(hb);
  assign s_htrans = blk ? IDLE : htrans_type'(htr);
  assign s_hsel   = |hgrant & !blk;
  assign s_hwdata = dp_valid_q ? wd_y : '0;
  assign s_hready = hready_eff;
  assign m_hrdata = s_hrdata;
  assign hwait    = ~hready_eff;
  assign hburst   = s_hburst;
  always_comb
    for (int i = 0; i < MASTER_NUM; i++) begin
      m_hready[i] = (hgrant[i] | dp_owner_q[i]) ? hready_eff : m_htrans[i] == IDLE;
      m_hresp[i]  = dp_owner_q[i] ? (err ? ERROR : s_hresp) : OKAY;
    end
  always_comb begin
    dp_owner_d = clr ? '0 : hready_eff ? gnt : dp_owner_q;
    dp_valid_d = clr ? 1'b0 : hready_eff ? (|hgrant & is_active(s_htrans)) : dp_valid_q;
  end
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      dp_owner_q <= '0;
      dp_valid_q <= 1'b0;
    end else begin
      dp_owner_q <= dp_owner_d;
      dp_valid_q <= dp_valid_d;
    end
`ifdef SLAVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) > 4 ? $clog2(TIMEOUT + 1) : 4;
  wd_state_t st_q, st_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  always_comb begin
    st_d   = st_q;
    wcnt_d = '0;
    case (st_q)
      WD_IDLE: if (dp_valid_q && !s_hreadyout) begin
        st_d   = WD_WAIT;
        wcnt_d = CW'(1);
      end
      WD_WAIT: if (s_hreadyout) st_d = WD_IDLE;
        else if (wcnt_q == CW'(TIMEOUT - 1)) st_d = WD_ERR1;
        else wcnt_d = wcnt_q + CW'(!(&wcnt_q));
      WD_ERR1:  st_d = WD_ERR2;
      WD_ERR2:  st_d = WD_DRAIN;
      WD_DRAIN: st_d = s_hreadyout ? WD_IDLE : WD_DRAIN;
      default:  st_d = WD_IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge hreset_n)
    if (!hreset_n) begin
      st_q   <= WD_IDLE;
      wcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
    end
  assign hready_eff = st_q == WD_ERR2 ? 1'b1 : (st_q == WD_ERR1 || st_q == WD_DRAIN) ? 1'b0 : s_hreadyout;
  assign blk = st_q == WD_ERR1 || st_q == WD_ERR2 || st_q == WD_DRAIN;
  assign err = st_q == WD_ERR1 || st_q == WD_ERR2;
  assign clr = st_q == WD_ERR2;
`else
  assign hready_eff = s_hreadyout;
  assign blk = 1'b0;
  assign err = 1'b0;
  assign clr = 1'b0;
`endif
`ifndef SYNTHESIS
  // A non-one-hot grant is an arbiter bug; the mux still resolves it lowest-index first.
  always_ff @(posedge hclk) if (hreset_n) assert ($onehot0(hgrant));
`endif
endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// tb_ahb_slave_port_mux: directed self-checking bench for ahb_slave_port_mux.
module tb_ahb_slave_port_mux;
  import ahb_slave_port_mux_pkg::*;
  logic hclk, hreset_n;
  logic [2:0] hgrant;
  logic [2:0][31:0] m_haddr, m_hwdata;
  htrans_type [2:0] m_htrans;
  logic [2:0] m_hwrite;
  logic [2:0][2:0] m_hsize;
  hburst_type [2:0] m_hburst;
  logic [31:0] m_hrdata, s_haddr, s_hwdata, s_hrdata;
  logic [2:0] m_hready;
  hresp_type [2:0] m_hresp;
  logic s_hsel, s_hwrite, s_hready, s_hreadyout, hwait;
  htrans_type s_htrans;
  logic [2:0] s_hsize;
  hburst_type s_hburst, hburst;
  hresp_type s_hresp;
  int pass_cnt = 0, tot_cnt = 0;

  ahb_slave_port_mux #(.MASTER_NUM(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hgrant(hgrant), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
    .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp), .s_hsel(s_hsel),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hreadyout(s_hreadyout),
    .s_hrdata(s_hrdata), .s_hresp(s_hresp), .hwait(hwait), .hburst(hburst));

  initial hclk = 0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    hgrant = 0;
    m_htrans = {IDLE, IDLE, IDLE};
    s_hreadyout = 1;
    s_hresp = OKAY;
    tick();
  endtask

  task automatic test_reset();
    hreset_n = 0; hgrant = 0; m_haddr = '0; m_hwdata = '0; m_hwrite = 0; m_hsize = '0;
    m_htrans = {IDLE, IDLE, IDLE}; m_hburst = {SINGLE, SINGLE, SINGLE};
    s_hreadyout = 1; s_hresp = OKAY; s_hrdata = 32'hCAFE_0001;
    #2;
    tot_cnt++; if (s_hsel !== 1'b0) $display("FAIL rst_hsel got=%b exp=0", s_hsel); else pass_cnt++;
    tot_cnt++; if (s_htrans !== IDLE) $display("FAIL rst_htrans got=%0d exp=0", s_htrans); else pass_cnt++;
    tot_cnt++; if (s_hwdata !== 32'h0) $display("FAIL rst_hwdata got=%h exp=0", s_hwdata); else pass_cnt++;
    tot_cnt++; if (m_hresp !== {OKAY, OKAY, OKAY}) $display("FAIL rst_hresp got=%b exp=0", m_hresp); else pass_cnt++;
    tot_cnt++; if (m_hready !== 3'b111) $display("FAIL rst_hready got=%b exp=111", m_hready); else pass_cnt++;
    tot_cnt++; if (hwait !== 1'b0) $display("FAIL rst_hwait got=%b exp=0", hwait); else pass_cnt++;
    s_hreadyout = 0;
    #1;
    tot_cnt++; if (hwait !== 1'b1) $display("FAIL rst_hwait_busy got=%b exp=1", hwait); else pass_cnt++;
    tot_cnt++; if (m_hrdata !== 32'hCAFE_0001) $display("FAIL hrdata got=%h exp=cafe0001", m_hrdata); else pass_cnt++;
    s_hreadyout = 1;
    tick(); tick();
    hreset_n = 1;
    tick();
  endtask

  task automatic test_single_write();
    idle();
    hgrant = 3'b010; m_htrans[1] = NONSEQ; m_haddr[1] = 32'h100; m_hwrite[1] = 1;
    m_hwdata[1] = 32'hA5A5_1234; m_hsize[1] = 3'd2;
    #1;
    tot_cnt++; if (s_haddr !== 32'h100) $display("FAIL wr_haddr got=%h exp=100", s_haddr); else pass_cnt++;
    tot_cnt++; if (s_hsel !== 1'b1) $display("FAIL wr_hsel got=%b exp=1", s_hsel); else pass_cnt++;
    tot_cnt++; if (s_hwrite !== 1'b1 || s_hsize !== 3'd2) $display("FAIL wr_ctrl got=%b/%0d exp=1/2", s_hwrite, s_hsize); else pass_cnt++;
    tot_cnt++; if (s_hwdata !== 32'h0) $display("FAIL wr_hwdata_early got=%h exp=0", s_hwdata); else pass_cnt++;
    tick();
    hgrant = 0; m_htrans[1] = IDLE;
    #1;
    tot_cnt++; if (s_hwdata !== 32'hA5A5_1234) $display("FAIL wr_hwdata got=%h exp=a5a51234", s_hwdata); else pass_cnt++;
    tot_cnt++; if (s_hsel !== 1'b0 || s_htrans !== IDLE || s_haddr !== 32'h0) $display("FAIL wr_nogrant got=%b/%0d/%h exp=0/0/0", s_hsel, s_htrans, s_haddr); else pass_cnt++;
    tick();
    tot_cnt++; if (s_hwdata !== 32'h0) $display("FAIL wr_hwdata_after got=%h exp=0", s_hwdata); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    idle();
    hgrant = 3'b001; m_htrans[0] = NONSEQ; m_haddr[0] = 32'h200; m_hwrite[0] = 1; m_hburst[0] = INCR4;
    m_hwdata[0] = 32'hD000_0000;
    #1;
    tot_cnt++; if (s_hburst !== INCR4 || hburst !== INCR4) $display("FAIL ws_hburst got=%0d/%0d exp=3", s_hburst, hburst); else pass_cnt++;
    tick();
    m_htrans[0] = SEQ; m_haddr[0] = 32'h204; m_hwdata[0] = 32'hD000_0001; s_hreadyout = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tot_cnt++; if (m_hready[0] !== 1'b0 || hwait !== 1'b1) $display("FAIL ws_stall%0d got=%b/%b exp=0/1", k, m_hready[0], hwait); else pass_cnt++;
      tot_cnt++; if (s_hwdata !== 32'hD000_0001 || s_haddr !== 32'h204) $display("FAIL ws_hold%0d got=%h/%h exp=d0000001/204", k, s_hwdata, s_haddr); else pass_cnt++;
      tick();
    end
    s_hreadyout = 1;
    #1;
    tot_cnt++; if (m_hready[0] !== 1'b1 || hwait !== 1'b0) $display("FAIL ws_release got=%b/%b exp=1/0", m_hready[0], hwait); else pass_cnt++;
    tick();
    m_htrans[0] = IDLE; hgrant = 0; m_hwdata[0] = 32'hD000_0002;
    #1;
    tot_cnt++; if (s_hwdata !== 32'hD000_0002) $display("FAIL ws_beat2 got=%h exp=d0000002", s_hwdata); else pass_cnt++;
  endtask

  task automatic test_grant_switch();
    idle();
    hgrant = 3'b001; m_htrans[0] = NONSEQ; m_haddr[0] = 32'h300; m_hwdata[0] = 32'h0000_00A0;
    m_htrans[2] = NONSEQ; m_haddr[2] = 32'h400; m_hwdata[2] = 32'h0000_00C0;
    #1;
    tot_cnt++; if (m_hready[2] !== 1'b0) $display("FAIL gs_stall got=%b exp=0", m_hready[2]); else pass_cnt++;
    tot_cnt++; if (s_haddr !== 32'h300) $display("FAIL gs_addr0 got=%h exp=300", s_haddr); else pass_cnt++;
    tick();
    hgrant = 3'b100; m_htrans[0] = IDLE;
    #1;
    tot_cnt++; if (s_haddr !== 32'h400) $display("FAIL gs_addr2 got=%h exp=400", s_haddr); else pass_cnt++;
    tot_cnt++; if (s_hwdata !== 32'h0000_00A0) $display("FAIL gs_data0 got=%h exp=a0", s_hwdata); else pass_cnt++;
    tot_cnt++; if (m_hready !== 3'b111) $display("FAIL gs_ready got=%b exp=111", m_hready); else pass_cnt++;
    tick();
    hgrant = 0; m_htrans[2] = IDLE;
    #1;
    tot_cnt++; if (s_hwdata !== 32'h0000_00C0) $display("FAIL gs_data2 got=%h exp=c0", s_hwdata); else pass_cnt++;
  endtask

  task automatic test_slave_error();
    idle();
    hgrant = 3'b010; m_htrans[1] = NONSEQ; m_hwrite[1] = 0; m_haddr[1] = 32'h500;
    tick();
    hgrant = 0; m_htrans[1] = IDLE; s_hreadyout = 0; s_hresp = ERROR;
    #1;
    tot_cnt++; if (m_hresp[1] !== ERROR || m_hready[1] !== 1'b0) $display("FAIL err1 got=%0d/%b exp=1/0", m_hresp[1], m_hready[1]); else pass_cnt++;
    tot_cnt++; if (m_hresp[0] !== OKAY || m_hresp[2] !== OKAY) $display("FAIL err_others got=%0d/%0d exp=0/0", m_hresp[0], m_hresp[2]); else pass_cnt++;
    tick();
    s_hreadyout = 1;
    #1;
    tot_cnt++; if (m_hresp[1] !== ERROR || m_hready[1] !== 1'b1) $display("FAIL err2 got=%0d/%b exp=1/1", m_hresp[1], m_hready[1]); else pass_cnt++;
    tick();
    s_hresp = OKAY;
  endtask

  task automatic test_reset_mid();
    idle();
    hgrant = 3'b001; m_htrans[0] = NONSEQ; m_hwrite[0] = 1; m_haddr[0] = 32'h600;
    tick();
    hgrant = 0; m_htrans[0] = IDLE; m_hwdata[0] = 32'h0000_0077; s_hreadyout = 0;
    #1;
    tot_cnt++; if (s_hwdata !== 32'h77 || hwait !== 1'b1) $display("FAIL rm_pre got=%h/%b exp=77/1", s_hwdata, hwait); else pass_cnt++;
    #1 hreset_n = 0;
    #1;
    tot_cnt++; if (s_hwdata !== 32'h0) $display("FAIL rm_hwdata got=%h exp=0", s_hwdata); else pass_cnt++;
    tot_cnt++; if (m_hready !== 3'b111 || m_hresp !== {OKAY, OKAY, OKAY}) $display("FAIL rm_resp got=%b/%b exp=111/0", m_hready, m_hresp); else pass_cnt++;
    s_hreadyout = 1;
    tick();
    hreset_n = 1;
    tick();
  endtask

`ifdef SLAVE_TIMEOUT_EN
  task automatic test_watchdog();
    idle();
    hgrant = 3'b001; m_htrans[0] = NONSEQ; m_haddr[0] = 32'h700;
    tick();
    hgrant = 0; m_htrans[0] = IDLE; s_hreadyout = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      tot_cnt++; if (m_hready[0] !== 1'b0 || m_hresp[0] !== OKAY) $display("FAIL wd_wait%0d got=%b/%0d exp=0/0", k, m_hready[0], m_hresp[0]); else pass_cnt++;
      tick();
    end
    tot_cnt++; if (m_hready[0] !== 1'b0 || m_hresp[0] !== ERROR) $display("FAIL wd_err1 got=%b/%0d exp=0/1", m_hready[0], m_hresp[0]); else pass_cnt++;
    tick();
    tot_cnt++; if (m_hready[0] !== 1'b1 || m_hresp[0] !== ERROR) $display("FAIL wd_err2 got=%b/%0d exp=1/1", m_hready[0], m_hresp[0]); else pass_cnt++;
    tick();
    hgrant = 3'b010; m_htrans[1] = NONSEQ;
    #1;
    tot_cnt++; if (s_hsel !== 1'b0 || s_htrans !== IDLE || hwait !== 1'b1) $display("FAIL wd_drain got=%b/%0d/%b exp=0/0/1", s_hsel, s_htrans, hwait); else pass_cnt++;
    tot_cnt++; if (m_hresp[0] !== OKAY) $display("FAIL wd_drain_resp got=%0d exp=0", m_hresp[0]); else pass_cnt++;
    s_hreadyout = 1;
    tick();
    tot_cnt++; if (hwait !== 1'b0 || s_hsel !== 1'b1) $display("FAIL wd_recover got=%b/%b exp=0/1", hwait, s_hsel); else pass_cnt++;
    idle();
    hgrant = 3'b001; m_htrans[0] = NONSEQ;
    tick();
    hgrant = 0; m_htrans[0] = IDLE; s_hreadyout = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      tot_cnt++; if (m_hready[0] !== 1'b0) $display("FAIL wd_ok_wait%0d got=%b exp=0", k, m_hready[0]); else pass_cnt++;
      tick();
    end
    s_hreadyout = 1;
    #1;
    tot_cnt++; if (m_hready[0] !== 1'b1 || m_hresp[0] !== OKAY) $display("FAIL wd_ok_last got=%b/%0d exp=1/0", m_hready[0], m_hresp[0]); else pass_cnt++;
    tick();
    tot_cnt++; if (hwait !== 1'b0 || m_hresp[0] !== OKAY) $display("FAIL wd_ok_after got=%b/%0d exp=0/0", hwait, m_hresp[0]); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_wait_states();
    test_grant_switch();
    test_slave_error();
    test_reset_mid();
`ifdef SLAVE_TIMEOUT_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
